// File: rtl/flag_cmd_driver_pkg.sv
// Shared state encodings and cell command constants for the flag command driver.
package flag_cmd_driver_pkg;

    typedef enum logic [2:0] {
        FC_IDLE  = 3'd0,
        FC_SCAN  = 3'd1,
        FC_ISSUE = 3'd2,
        FC_CHECK = 3'd3,
        FC_DONE  = 3'd4
    } fc_state_e;

    localparam logic [1:0] FC_CMD_HOLD = 2'b00;
    localparam logic [1:0] FC_CMD_SET  = 2'b01;
    localparam logic [1:0] FC_CMD_CLR  = 2'b10;

    function automatic logic [1:0] fc_cmd_for(input logic target_bit);
        return target_bit ? FC_CMD_SET : FC_CMD_CLR;
    endfunction

endpackage

// File: rtl/flag_cmd_driver_err_counter.sv
// 8-bit saturating mismatch counter with synchronous clear.
module flag_err_counter (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] cnt_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/flag_cmd_driver.sv
// Walks an array of set/clear flag cells, commanding only cells whose readback
// differs from the captured target, then verifies each commanded cell.
module flag_cmd_driver #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req_target,
    input  logic [N-1:0]     flag_q,
    output logic [1:0]       cmd_b,
    output logic [IDX_W-1:0] cmd_sel,
    output logic             cmd_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt
);

    import flag_cmd_driver_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    fc_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     tgt_q, tgt_d;
    logic             err_q, err_d;
    logic             err_inc;
    logic             is_last;

    assign is_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tgt_d   = tgt_q;
        err_d   = 1'b0;
        err_inc = 1'b0;
        unique case (state_q)
            FC_IDLE: begin
                if (req_valid) begin
                    tgt_d   = req_target;
                    idx_d   = '0;
                    state_d = FC_SCAN;
                end
            end
            FC_SCAN: begin
                if (tgt_q[idx_q] != flag_q[idx_q]) begin
                    state_d = FC_ISSUE;
                end else if (is_last) begin
                    state_d = FC_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            FC_ISSUE: begin
                state_d = FC_CHECK;
            end
            FC_CHECK: begin
                // The cell latched its command on the edge that ended ISSUE,
                // so the readback here already reflects it.
                if (tgt_q[idx_q] != flag_q[idx_q]) begin
                    err_d   = 1'b1;
                    err_inc = 1'b1;
                end
                if (is_last) begin
                    state_d = FC_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = FC_SCAN;
                end
            end
            FC_DONE: begin
                state_d = FC_IDLE;
            end
            default: begin
                state_d = FC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FC_IDLE;
            idx_q   <= '0;
            tgt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
        end
    end

    flag_err_counter u_err_counter (
        .clk_i (clock),
        .clr_i (reset),
        .inc_i (err_inc),
        .cnt_o (err_cnt)
    );

    // Outputs decode only registered state; no input reaches an output combinationally.
    assign req_ready = (state_q == FC_IDLE);
    assign busy      = (state_q != FC_IDLE);
    assign done      = (state_q == FC_DONE);
    assign cmd_valid = (state_q == FC_ISSUE);
    assign cmd_b     = (state_q == FC_ISSUE) ? fc_cmd_for(tgt_q[idx_q]) : FC_CMD_HOLD;
    assign cmd_sel   = (state_q == FC_ISSUE) ? idx_q : '0;
    assign err       = err_q;

endmodule

// File: tb/tb_flag_cmd_driver.sv
// Directed bench for flag_cmd_driver with a two-cell set/clear model.
module tb_flag_cmd_driver;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_target;
    logic [1:0] flag_q;
    logic [1:0] cmd_b;
    logic [0:0] cmd_sel;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] err_cnt;

    int n_checks;
    int n_errors;

    // Cell model: latches a command on the edge ending ISSUE; cell 1 can be stuck at 0.
    logic [1:0] cells;
    logic       ld_en;
    logic [1:0] ld_val;
    logic       stuck1;

    // Per-request trace
    int         ncmd;
    int         cmd_cyc [4];
    logic [1:0] cmd_bv  [4];
    logic       cmd_sv  [4];
    int         done_cyc;
    int         err_cyc;
    int         nerr;
    logic       busy_c1;
    logic       ready_c1;

    flag_cmd_driver #(.N(2), .IDX_W(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .flag_q     (flag_q),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ld_en) begin
            cells <= ld_val;
        end else if (cmd_valid) begin
            if (cmd_b == 2'b01) cells[cmd_sel] <= 1'b1;
            else if (cmd_b == 2'b10) cells[cmd_sel] <= 1'b0;
        end
    end

    assign flag_q = cells & {~stuck1, 1'b1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic preset(input logic [1:0] v);
        @(negedge clock);
        ld_en  = 1'b1;
        ld_val = v;
        @(negedge clock);
        ld_en  = 1'b0;
    endtask

    // Handshake on edge 0, then trace cycles 1.. until done or the budget runs out.
    task automatic do_req(input logic [1:0] t);
        @(negedge clock);
        req_valid  = 1'b1;
        req_target = t;
        @(posedge clock);
        #1;
        req_valid  = 1'b0;
        req_target = ~t;
        ncmd     = 0;
        done_cyc = -1;
        err_cyc  = -1;
        nerr     = 0;
        for (int k = 1; k <= 20 && done_cyc < 0; k++) begin
            @(negedge clock);
            if (k == 1) begin
                busy_c1  = busy;
                ready_c1 = req_ready;
            end
            if (cmd_valid) begin
                if (ncmd < 4) begin
                    cmd_cyc[ncmd] = k;
                    cmd_bv[ncmd]  = cmd_b;
                    cmd_sv[ncmd]  = cmd_sel[0];
                end
                ncmd++;
            end
            if (err) begin
                nerr++;
                err_cyc = k;
            end
            if (done) done_cyc = k;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_target = 2'b00;
        ld_en      = 1'b1;
        ld_val     = 2'b00;
        stuck1     = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        ld_en = 1'b0;
        reset = 1'b0;
        check("rst_ready",   {31'd0, req_ready}, 1);
        check("rst_cmd_b",   {30'd0, cmd_b},     0);
        check("rst_cmd_vld", {31'd0, cmd_valid}, 0);
        check("rst_busy",    {31'd0, busy},      0);
        check("rst_done",    {31'd0, done},      0);
        check("rst_err_cnt", {24'd0, err_cnt},   0);

        // 00 -> 11: both cells set
        preset(2'b00);
        do_req(2'b11);
        check("t1_busy_c1",  {31'd0, busy_c1},  1);
        check("t1_ready_c1", {31'd0, ready_c1}, 0);
        check("t1_ncmd",     ncmd, 2);
        check("t1_c0_cyc",   cmd_cyc[0], 2);
        check("t1_c0_b",     {30'd0, cmd_bv[0]}, 1);
        check("t1_c0_sel",   {31'd0, cmd_sv[0]}, 0);
        check("t1_c1_cyc",   cmd_cyc[1], 5);
        check("t1_c1_b",     {30'd0, cmd_bv[1]}, 1);
        check("t1_c1_sel",   {31'd0, cmd_sv[1]}, 1);
        check("t1_done_cyc", done_cyc, 7);
        check("t1_nerr",     nerr, 0);
        check("t1_flags",    {30'd0, flag_q}, 3);
        @(negedge clock);
        check("t1_ready_after", {31'd0, req_ready}, 1);
        check("t1_done_after",  {31'd0, done}, 0);

        // Target already matches: no commands
        preset(2'b10);
        do_req(2'b10);
        check("t2_ncmd",     ncmd, 0);
        check("t2_done_cyc", done_cyc, 3);
        check("t2_flags",    {30'd0, flag_q}, 2);

        // 01 -> 10: clear cell 0, set cell 1
        preset(2'b01);
        do_req(2'b10);
        check("t3_ncmd",     ncmd, 2);
        check("t3_c0_cyc",   cmd_cyc[0], 2);
        check("t3_c0_b",     {30'd0, cmd_bv[0]}, 2);
        check("t3_c0_sel",   {31'd0, cmd_sv[0]}, 0);
        check("t3_c1_cyc",   cmd_cyc[1], 5);
        check("t3_c1_b",     {30'd0, cmd_bv[1]}, 1);
        check("t3_c1_sel",   {31'd0, cmd_sv[1]}, 1);
        check("t3_done_cyc", done_cyc, 7);
        check("t3_flags",    {30'd0, flag_q}, 2);
        check("t3_nerr",     nerr, 0);

        // Cell 1 stuck at 0: one command, one error, walk still completes
        stuck1 = 1'b1;
        preset(2'b00);
        do_req(2'b10);
        check("t4_ncmd",     ncmd, 1);
        check("t4_c0_cyc",   cmd_cyc[0], 3);
        check("t4_c0_sel",   {31'd0, cmd_sv[0]}, 1);
        check("t4_nerr",     nerr, 1);
        check("t4_err_cyc",  err_cyc, 5);
        check("t4_done_cyc", done_cyc, 5);
        check("t4_err_cnt",  {24'd0, err_cnt}, 1);

        // Reset during ISSUE
        stuck1 = 1'b0;
        preset(2'b00);
        @(negedge clock);
        req_valid  = 1'b1;
        req_target = 2'b01;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("t5_in_issue", {31'd0, cmd_valid}, 1);
        reset = 1'b1;
        @(negedge clock);
        check("t5_ready",   {31'd0, req_ready}, 1);
        check("t5_cmd_b",   {30'd0, cmd_b},     0);
        check("t5_cmd_vld", {31'd0, cmd_valid}, 0);
        check("t5_busy",    {31'd0, busy},      0);
        check("t5_done",    {31'd0, done},      0);
        check("t5_err_cnt", {24'd0, err_cnt},   0);
        reset = 1'b0;
        nerr = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (done) nerr++;
        end
        check("t5_no_done", nerr, 0);

        // Saturation: 256 failing requests
        stuck1 = 1'b1;
        preset(2'b00);
        for (int r = 0; r < 255; r++) begin
            do_req(2'b10);
        end
        check("t6_cnt_255", {24'd0, err_cnt}, 255);
        do_req(2'b10);
        check("t6_err_pulse", nerr, 1);
        check("t6_done_cyc",  done_cyc, 5);
        check("t6_cnt_sat",   {24'd0, err_cnt}, 255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
